// File: rtl/tron_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tron_pkg
//  Description : Shared types and constants for the Tron game sequencer:
//                the game state encoding seen by the score block, winner
//                codes and default frame counts.
//  Revision    : 1.0 - initial release
// ============================================================================
package tron_pkg;

    // Game_State encoding; MENU (0) doubles as the score block's clear.
    typedef enum logic [2:0] {
        ST_MENU       = 3'd0,
        ST_COUNTDOWN  = 3'd1,
        ST_PLAYING    = 3'd2,
        ST_ROUND_OVER = 3'd3,
        ST_GAME_OVER  = 3'd4,
        ST_PAUSED     = 3'd5
    } game_state_t;

    // Winner codes; bit 1 = red, bit 0 = blue, so both set reads as a draw.
    localparam logic [1:0] c_WINNER_NONE = 2'd0;
    localparam logic [1:0] c_WINNER_BLUE = 2'd1;
    localparam logic [1:0] c_WINNER_RED  = 2'd2;
    localparam logic [1:0] c_WINNER_DRAW = 2'd3;

    localparam int c_COUNTDOWN_FRAMES_DEF  = 60;
    localparam int c_ROUND_OVER_FRAMES_DEF = 90;

    // First digit shown when a countdown starts.
    localparam logic [1:0] c_COUNTDOWN_FIRST = 2'd3;

    // Frame counts are held in an 8-bit counter.
    function automatic logic [7:0] frames_to_count(input int frames);
        return 8'(frames);
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : edge_detect
//  Description : Two-flop synchronizer followed by a rising-edge detector.
//                Produces a single-cycle pulse per low-to-high transition
//                of an asynchronous or slow level input.
//  Ports       : Clk    - system clock
//                Reset  - synchronous active-high reset
//                i_sig  - level input (any domain)
//                o_rise - one-cycle pulse in the Clk domain
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_detect (
    input  logic Clk,
    input  logic Reset,
    input  logic i_sig,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_sig;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_rise = r_sync2 & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : game_sequencer
//  Description : Top-level game flow controller for the Tron bike game:
//                MENU -> COUNTDOWN (3,2,1) -> PLAYING -> ROUND_OVER /
//                GAME_OVER, timed by the frame clock.
//  Config      : TRON_PAUSE_EN - adds the pause_key port and PAUSED state.
//  Ports       : Clk, Reset           - clock, synchronous active-high reset
//                frame_clk            - ~60 Hz frame clock (resynchronised)
//                start_key, pause_key - key levels, rising edges act
//                reset_round          - pulse: a round was lost
//                Blue_W, Red_W        - win flags from the score block
//                Game_State           - current state code
//                countdown            - digit 3/2/1 in COUNTDOWN, else 0
//                move_en              - bikes may advance (PLAYING only)
//                round_init           - pulse on each entry to COUNTDOWN
//                winner               - 0 none, 1 blue, 2 red, 3 draw
//  Revision    : 1.0 - initial release
// ============================================================================
module game_sequencer
    import tron_pkg::*;
#(
    parameter int COUNTDOWN_FRAMES  = c_COUNTDOWN_FRAMES_DEF,
    parameter int ROUND_OVER_FRAMES = c_ROUND_OVER_FRAMES_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       start_key,
`ifdef TRON_PAUSE_EN
    input  logic       pause_key,
`endif
    input  logic       reset_round,
    input  logic       Blue_W,
    input  logic       Red_W,
    output logic [2:0] Game_State,
    output logic [1:0] countdown,
    output logic       move_en,
    output logic       round_init,
    output logic [1:0] winner
);

    localparam logic [7:0] c_CD_LOAD = frames_to_count(COUNTDOWN_FRAMES);
    localparam logic [7:0] c_RO_LOAD = frames_to_count(ROUND_OVER_FRAMES);

    game_state_t r_state;
    game_state_t w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic [1:0]  r_digit;
    logic [1:0]  w_digit_nxt;
    logic [1:0]  r_winner;
    logic [1:0]  w_winner_nxt;
    logic        r_move_en;
    logic        r_round_init;

    logic        w_frame_tick;
    logic        w_start_rise;
    logic        w_win;
    logic        w_expire;
    logic        w_entering;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    edge_detect u_frame_edge (
        .Clk    (Clk),
        .Reset  (Reset),
        .i_sig  (frame_clk),
        .o_rise (w_frame_tick)
    );

    edge_detect u_start_edge (
        .Clk    (Clk),
        .Reset  (Reset),
        .i_sig  (start_key),
        .o_rise (w_start_rise)
    );

`ifdef TRON_PAUSE_EN
    logic w_pause_rise;

    edge_detect u_pause_edge (
        .Clk    (Clk),
        .Reset  (Reset),
        .i_sig  (pause_key),
        .o_rise (w_pause_rise)
    );
`endif

    assign w_win    = Blue_W | Red_W;
    assign w_expire = w_frame_tick && (r_cnt == 8'd1);

    // ------------------------------------------------------------------
    // Next-state logic; win flags outrank reset_round, which outranks pause.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_MENU: begin
                if (w_start_rise)
                    w_state_nxt = ST_COUNTDOWN;
            end
            ST_COUNTDOWN: begin
                if (w_expire && (r_digit == 2'd1))
                    w_state_nxt = ST_PLAYING;
            end
            ST_PLAYING: begin
                if (w_win)
                    w_state_nxt = ST_GAME_OVER;
                else if (reset_round)
                    w_state_nxt = ST_ROUND_OVER;
`ifdef TRON_PAUSE_EN
                else if (w_pause_rise)
                    w_state_nxt = ST_PAUSED;
`endif
            end
            ST_ROUND_OVER: begin
                // The score block raises a win one cycle after reset_round,
                // so a win here must still end the game.
                if (w_win)
                    w_state_nxt = ST_GAME_OVER;
                else if (w_expire)
                    w_state_nxt = ST_COUNTDOWN;
            end
            ST_GAME_OVER: begin
                if (w_start_rise)
                    w_state_nxt = ST_MENU;
            end
`ifdef TRON_PAUSE_EN
            ST_PAUSED: begin
                if (w_win)
                    w_state_nxt = ST_GAME_OVER;
                else if (reset_round)
                    w_state_nxt = ST_ROUND_OVER;
                else if (w_pause_rise)
                    w_state_nxt = ST_PLAYING;
            end
`endif
            default: w_state_nxt = ST_MENU;
        endcase
    end

    // ------------------------------------------------------------------
    // Counter, digit and winner next values. Every state entry reloads the
    // frame counter; within COUNTDOWN each digit expiry reloads it again.
    // ------------------------------------------------------------------
    always_comb begin
        w_entering   = (w_state_nxt != r_state);
        w_cnt_nxt    = r_cnt;
        w_digit_nxt  = r_digit;
        w_winner_nxt = r_winner;

        if (w_entering) begin
            case (w_state_nxt)
                ST_COUNTDOWN:  w_cnt_nxt = c_CD_LOAD;
                ST_ROUND_OVER: w_cnt_nxt = c_RO_LOAD;
                default:       w_cnt_nxt = 8'd0;
            endcase

            if (w_state_nxt == ST_COUNTDOWN)
                w_digit_nxt = c_COUNTDOWN_FIRST;
            else
                w_digit_nxt = 2'd0;

            if (w_state_nxt == ST_GAME_OVER)
                w_winner_nxt = {Red_W, Blue_W};
            else if (w_state_nxt == ST_MENU)
                w_winner_nxt = c_WINNER_NONE;
        end else if (w_frame_tick && (r_cnt != 8'd0)) begin
            if ((r_state == ST_COUNTDOWN) && (r_cnt == 8'd1)) begin
                w_cnt_nxt   = c_CD_LOAD;
                w_digit_nxt = r_digit - 2'd1;
            end else begin
                w_cnt_nxt = r_cnt - 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= ST_MENU;
            r_cnt        <= 8'd0;
            r_digit      <= 2'd0;
            r_winner     <= c_WINNER_NONE;
            r_move_en    <= 1'b0;
            r_round_init <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_digit      <= w_digit_nxt;
            r_winner     <= w_winner_nxt;
            r_move_en    <= (w_state_nxt == ST_PLAYING);
            r_round_init <= w_entering && (w_state_nxt == ST_COUNTDOWN);
        end
    end

    assign Game_State = r_state;
    assign countdown  = r_digit;
    assign move_en    = r_move_en;
    assign round_init = r_round_init;
    assign winner     = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_sequencer
//  Description : Self-checking directed bench for game_sequencer with
//                COUNTDOWN_FRAMES=2, ROUND_OVER_FRAMES=3. Expected output
//                snapshots are queued when stimulus is applied and popped
//                for comparison once the DUT has responded.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_clk = 1'b0;
    logic       start_key = 1'b0;
`ifdef TRON_PAUSE_EN
    logic       pause_key = 1'b0;
`endif
    logic       reset_round = 1'b0;
    logic       blue_w = 1'b0;
    logic       red_w = 1'b0;
    logic [2:0] game_state;
    logic [1:0] countdown;
    logic       move_en;
    logic       round_init;
    logic [1:0] winner;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] cd;
        logic       mv;
        logic [1:0] win;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_init = 0;
    int n0     = 0;

    game_sequencer #(
        .COUNTDOWN_FRAMES  (2),
        .ROUND_OVER_FRAMES (3)
    ) dut (
        .Clk         (clk),
        .Reset       (rst),
        .frame_clk   (frame_clk),
        .start_key   (start_key),
`ifdef TRON_PAUSE_EN
        .pause_key   (pause_key),
`endif
        .reset_round (reset_round),
        .Blue_W      (blue_w),
        .Red_W       (red_w),
        .Game_State  (game_state),
        .countdown   (countdown),
        .move_en     (move_en),
        .round_init  (round_init),
        .winner      (winner)
    );

    always #5 clk = ~clk;

    // Pulse counter for round_init, sampled away from the active edge.
    always @(negedge clk) begin
        if (round_init === 1'b1)
            n_init <= n_init + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [2:0] st, input logic [1:0] cd,
                        input logic mv, input logic [1:0] win);
        exp_t e;
        e.st  = st;
        e.cd  = cd;
        e.mv  = mv;
        e.win = win;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic pop_check();
        exp_t  e;
        string t;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk({t, ".state"},     {5'd0, game_state}, {5'd0, e.st});
            chk({t, ".countdown"}, {6'd0, countdown},  {6'd0, e.cd});
            chk({t, ".move_en"},   {7'd0, move_en},    {7'd0, e.mv});
            chk({t, ".winner"},    {6'd0, winner},     {6'd0, e.win});
        end
    endtask

    // One frame_clk period: rise is seen by the DUT three Clk edges later.
    task automatic frame();
        frame_clk = 1'b1;
        step(3);
        frame_clk = 1'b0;
        step(3);
    endtask

    task automatic press_start();
        start_key = 1'b1;
        step(3);
        start_key = 1'b0;
        step(3);
    endtask

    // From MENU to PLAYING: start, then three digits of two frames each.
    task automatic go_playing(input string tag);
        press_start();
        repeat (6) frame();
        push(tag, 3'd2, 2'd0, 1'b1, 2'd0);
        pop_check();
    endtask

    initial begin
        // Reset state
        step(3);
        rst = 1'b0;
        step(1);
        push("reset", 3'd0, 2'd0, 1'b0, 2'd0);
        pop_check();
        chk("reset.round_init", {7'd0, round_init}, 8'd0);

        // reset_round in MENU is ignored
        reset_round = 1'b1;
        step(1);
        reset_round = 1'b0;
        step(2);
        push("menu_reset_round", 3'd0, 2'd0, 1'b0, 2'd0);
        pop_check();

        // Start edge -> COUNTDOWN with digit 3 and round_init in first cycle
        n0 = n_init;
        push("start", 3'd1, 2'd3, 1'b0, 2'd0);
        start_key = 1'b1;
        step(3);
        pop_check();
        chk("start.round_init_first_cycle", {7'd0, round_init}, 8'd1);
        start_key = 1'b0;
        step(3);
        chk("start.round_init_count", 8'(n_init - n0), 8'd1);

        // Countdown digits
        push("digit2", 3'd1, 2'd2, 1'b0, 2'd0);
        frame();
        frame();
        pop_check();
        push("digit1", 3'd1, 2'd1, 1'b0, 2'd0);
        frame();
        frame();
        pop_check();
        push("playing", 3'd2, 2'd0, 1'b1, 2'd0);
        frame();
        frame();
        pop_check();

        // start_key ignored while PLAYING
        press_start();
        push("playing_start_ignored", 3'd2, 2'd0, 1'b1, 2'd0);
        pop_check();

        // reset_round -> ROUND_OVER, hold 3 ticks, then COUNTDOWN
        push("round_over", 3'd3, 2'd0, 1'b0, 2'd0);
        reset_round = 1'b1;
        step(1);
        reset_round = 1'b0;
        pop_check();
        n0 = n_init;
        frame();
        frame();
        push("round_over_hold", 3'd3, 2'd0, 1'b0, 2'd0);
        pop_check();
        frame();
        push("round_restart", 3'd1, 2'd3, 1'b0, 2'd0);
        pop_check();
        chk("round_restart.round_init_count", 8'(n_init - n0), 8'd1);
        repeat (6) frame();
        push("playing2", 3'd2, 2'd0, 1'b1, 2'd0);
        pop_check();

        // reset_round then Red_W next cycle -> GAME_OVER, red wins
        push("red_win", 3'd4, 2'd0, 1'b0, 2'd2);
        reset_round = 1'b1;
        step(1);
        reset_round = 1'b0;
        red_w = 1'b1;
        step(1);
        red_w = 1'b0;
        step(2);
        pop_check();
        push("red_win_to_menu", 3'd0, 2'd0, 1'b0, 2'd0);
        press_start();
        pop_check();

        // All three flags together -> draw
        go_playing("playing3");
        push("draw", 3'd4, 2'd0, 1'b0, 2'd3);
        blue_w = 1'b1;
        red_w = 1'b1;
        reset_round = 1'b1;
        step(1);
        blue_w = 1'b0;
        red_w = 1'b0;
        reset_round = 1'b0;
        step(2);
        pop_check();
        press_start();
        push("draw_to_menu", 3'd0, 2'd0, 1'b0, 2'd0);
        pop_check();

        // Held start key gives exactly one COUNTDOWN entry
        n0 = n_init;
        start_key = 1'b1;
        step(100);
        push("held_start", 3'd1, 2'd3, 1'b0, 2'd0);
        pop_check();
        chk("held_start.round_init_count", 8'(n_init - n0), 8'd1);
        start_key = 1'b0;
        step(5);
        frame();

        // Reset mid-COUNTDOWN
        n0 = n_init;
        rst = 1'b1;
        step(1);
        push("mid_reset", 3'd0, 2'd0, 1'b0, 2'd0);
        pop_check();
        rst = 1'b0;
        step(10);
        push("mid_reset_stays_menu", 3'd0, 2'd0, 1'b0, 2'd0);
        pop_check();
        chk("mid_reset.round_init_count", 8'(n_init - n0), 8'd0);

`ifdef TRON_PAUSE_EN
        go_playing("playing_pause");
        pause_key = 1'b1;
        step(3);
        push("paused", 3'd5, 2'd0, 1'b0, 2'd0);
        pop_check();
        pause_key = 1'b0;
        step(3);
        pause_key = 1'b1;
        step(3);
        push("unpaused", 3'd2, 2'd0, 1'b1, 2'd0);
        pop_check();
        pause_key = 1'b0;
        step(3);
        pause_key = 1'b1;
        step(3);
        pause_key = 1'b0;
        step(1);
        push("paused_blue_win", 3'd4, 2'd0, 1'b0, 2'd1);
        blue_w = 1'b1;
        step(1);
        blue_w = 1'b0;
        step(1);
        pop_check();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter COUNTDOWN_FRAMES, default 60: frame ticks per countdown digit.
REQ-002 Parameter ROUND_OVER_FRAMES, default 90: frame ticks the round-over screen is held.
REQ-003 Clk  input  1  50 MHz system clock; all logic on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 frame_clk  input  1  ~60 Hz frame clock; sampled in the Clk domain.
REQ-006 start_key  input  1  level from keyboard decode; only rising edges act.
REQ-007 pause_key  input  1  level; port exists only when TRON_PAUSE_EN is defined.
REQ-008 reset_round  input  1  one-cycle pulse from the score block: a round was lost.
REQ-009 Blue_W, Red_W  input  1 each  win flags from the score block.
REQ-010 Game_State  output  3  current state encoding (REQ-014).
REQ-011 countdown  output  2  digit shown during COUNTDOWN (3, 2, 1); 0 otherwise.
REQ-012 move_en  output  1  bikes advance only while high; high only in PLAYING.
REQ-013 round_init  output  1  one-cycle pulse on every entry to COUNTDOWN: reload bike positions and clear trails.
REQ-013a winner  output  2  0 none, 1 blue, 2 red, 3 draw; latched at GAME_OVER entry.

Function
REQ-014 State encoding: MENU=0, COUNTDOWN=1, PLAYING=2, ROUND_OVER=3, GAME_OVER=4, PAUSED=5; Game_State=0 is the score block's clear condition.
REQ-015 frame_clk passes through a 2-flop synchronizer, then a rising-edge detector, giving a one-cycle frame_tick.
REQ-016 start_key and pause_key are each rising-edge detected; holding a key gives exactly one event.
REQ-017 Frame counter: 8-bit; loaded on each state entry; decremented on frame_tick; expiry is a tick arriving while the counter is 1.
REQ-018 MENU: start edge -> COUNTDOWN, with countdown=3 and round_init asserted in the first COUNTDOWN cycle.
REQ-019 COUNTDOWN: each digit lasts COUNTDOWN_FRAMES ticks; 3->2->1; expiry of digit 1 -> PLAYING on the next Clk.
REQ-020 PLAYING: Blue_W or Red_W -> GAME_OVER; else reset_round -> ROUND_OVER; win flags take priority when coincident with reset_round.
REQ-021 ROUND_OVER: hold ROUND_OVER_FRAMES ticks, then -> COUNTDOWN with a round_init pulse. Blue_W or Red_W arriving during the hold -> GAME_OVER immediately; the score block raises a win one cycle after reset_round.
REQ-022 GAME_OVER: winner = {Red_W, Blue_W} sampled at the entry cycle (both high = draw=3). A start edge -> MENU and clears winner to 0.
REQ-023 start_key is ignored in COUNTDOWN, PLAYING, ROUND_OVER and PAUSED.
REQ-024 reset_round outside PLAYING/PAUSED is ignored.
REQ-025 All outputs are registered; state change is visible on Game_State one Clk after the triggering event.

Reset
REQ-026 Reset takes priority over every input, in any state: next cycle Game_State=0, countdown=0, move_en=0, round_init=0, winner=0, counter=0, synchronizer and edge-detector flops=0.
REQ-027 Reset mid-round gives no round_init pulse; a fresh start edge is required to begin play.

Configuration
REQ-028 Macro TRON_PAUSE_EN defined: the pause_key port exists. A pause edge in PLAYING -> PAUSED (move_en=0); a pause edge in PAUSED -> PLAYING. In PAUSED, win flags and reset_round are handled as in PLAYING.
REQ-029 TRON_PAUSE_EN undefined: no pause_key port, no PAUSED state; encoding 5 is unreachable.

Structure
REQ-030 Shared package tron_pkg holds the game_state_t enum (REQ-014 values), the winner encoding constants, and default frame-count constants.
REQ-031 One sub-module, edge_detect (2-flop sync plus rising-edge pulse, Clk/Reset), is instantiated for frame_clk, start_key and, when enabled, pause_key.

Verification (COUNTDOWN_FRAMES=2, ROUND_OVER_FRAMES=3)
REQ-032 Reset, then a start edge -> Game_State 0->1, one round_init pulse, countdown 3,2,1 over 6 ticks, then Game_State=2 with move_en=1.
REQ-033 In PLAYING, pulse reset_round -> Game_State=3 and move_en=0. After 3 ticks, Game_State=1 with one round_init pulse.
REQ-034 In PLAYING, reset_round then Red_W on the next cycle -> Game_State=4 and winner=2. A start edge -> Game_State=0 and winner=0.
REQ-035 Blue_W, Red_W and reset_round high in the same cycle -> Game_State=4 and winner=3.
REQ-036 Hold start_key high for 100 cycles in MENU -> exactly one COUNTDOWN entry. Assert Reset mid-COUNTDOWN -> Game_State=0 on the next cycle and no round_init.
REQ-037 With TRON_PAUSE_EN: a pause edge in PLAYING -> Game_State=5, move_en=0. A second pause edge -> Game_State=2. A Blue_W pulse while PAUSED -> Game_State=4, winner=1.
